// File: rtl/psum_accum_buf_pkg.sv
// Shared constants and FSM state encoding for the psum accumulation buffer and PE array.
package psum_accum_buf_pkg;

    localparam int unsigned DEF_ADDR_PSUM = 12;
    localparam int unsigned DEF_PSUM_BW   = 32;
    localparam int unsigned DEF_INPUT_BW  = 8;

    // Width of OC*IMG_W (8-bit channels x 6-bit width)
    localparam int unsigned DIM_W = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/psum_requant.sv
// Combinational requantizer: rounding arithmetic right shift, optional ReLU, signed saturation.
module psum_requant #(
    parameter int unsigned PSUM_BW  = 32,
    parameter int unsigned INPUT_BW = 8
) (
    input  logic [PSUM_BW-1:0]  acc_i,
    input  logic [4:0]          shift_i,
    input  logic                relu_en_i,
    output logic [INPUT_BW-1:0] q_c_o
);
    localparam int unsigned EW = PSUM_BW + 1;
    localparam logic signed [EW-1:0] QMAX = {{(EW-INPUT_BW+1){1'b0}}, {(INPUT_BW-1){1'b1}}};
    localparam logic signed [EW-1:0] QMIN = {{(EW-INPUT_BW+1){1'b1}}, {(INPUT_BW-1){1'b0}}};

    logic signed [EW-1:0] rnd_c;
    logic signed [EW-1:0] sum_c;
    logic signed [EW-1:0] shr_c;

    // One guard bit keeps the rounding add from wrapping
    always_comb begin
        rnd_c = '0;
        if (shift_i != 5'd0) begin
            rnd_c = EW'(1) << (shift_i - 5'd1);
        end
        sum_c = $signed({acc_i[PSUM_BW-1], acc_i}) + rnd_c;
        shr_c = sum_c >>> shift_i;
        if (relu_en_i && shr_c[EW-1]) begin
            shr_c = '0;
        end
        if (shr_c > QMAX) begin
            q_c_o = QMAX[INPUT_BW-1:0];
        end else if (shr_c < QMIN) begin
            q_c_o = QMIN[INPUT_BW-1:0];
        end else begin
            q_c_o = shr_c[INPUT_BW-1:0];
        end
    end

endmodule

// File: rtl/psum_accum_buf.sv
// Per-tile psum accumulator: read-modify-write accumulation into a private buffer,
// then an in-order requantized byte drain with valid/ready backpressure.
module psum_accum_buf
    import psum_accum_buf_pkg::*;
#(
    parameter int unsigned ADDR_PSUM = DEF_ADDR_PSUM,
    parameter int unsigned PSUM_BW   = DEF_PSUM_BW,
    parameter int unsigned INPUT_BW  = DEF_INPUT_BW
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 acc_start,
    input  logic                 acc_last,
    input  logic                 drain_start,
    input  logic [5:0]           IMG_W,
    input  logic [7:0]           OC,
    input  logic [4:0]           shift,
    input  logic                 relu_en,
    input  logic                 psum_valid_in,
    input  logic [ADDR_PSUM-1:0] psum_addr_in,
    input  logic [PSUM_BW-1:0]   psum_data_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INPUT_BW-1:0]  out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);
    localparam int unsigned DEPTH = 2 ** ADDR_PSUM;
    localparam int unsigned CNT_W = DIM_W;

    state_e               state_q, state_d;
    logic                 first_pass_q, first_pass_d;
    logic                 drained_q, drained_d;
    logic                 last_seen_q, last_seen_d;
    logic [DEPTH-1:0]     written_q, written_d;

    logic                 s1_valid_q, s1_valid_d;
    logic [ADDR_PSUM-1:0] s1_addr_q, s1_addr_d;
    logic [PSUM_BW-1:0]   s1_data_q, s1_data_d;
    logic                 wb_valid_q;
    logic [ADDR_PSUM-1:0] wb_addr_q;
    logic [PSUM_BW-1:0]   wb_data_q;

    logic [CNT_W-1:0]     ptr_q, ptr_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 rd_wr_q, rd_wr_d;
    logic                 rd_last_q, rd_last_d;
    logic                 out_valid_q, out_valid_d;
    logic [INPUT_BW-1:0]  out_data_q, out_data_d;
    logic                 out_last_q, out_last_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [PSUM_BW-1:0]   mem [DEPTH];
    logic [PSUM_BW-1:0]   rd_data_q;

    logic [CNT_W-1:0]     n_beats_c;
    logic                 accept_c;
    logic                 adv_c;
    logic                 issue_c;
    logic                 rd_en_c;
    logic [ADDR_PSUM-1:0] rd_addr_c;
    logic                 fwd_c;
    logic                 hit_c;
    logic [PSUM_BW-1:0]   base_c;
    logic [PSUM_BW-1:0]   sum_c;
    logic [PSUM_BW-1:0]   req_acc_c;
    logic [INPUT_BW-1:0]  req_q_c;

    assign n_beats_c = CNT_W'(OC) * CNT_W'(IMG_W);
    assign accept_c  = (state_q == ACCUM) && psum_valid_in && !last_seen_q;
    assign adv_c     = !out_valid_q || out_ready;
    assign issue_c   = (state_q == DRAIN) && (ptr_q < n_beats_c) && (!rd_valid_q || adv_c);
    assign rd_en_c   = accept_c || issue_c;
    assign rd_addr_c = (state_q == DRAIN) ? ADDR_PSUM'(ptr_q) : psum_addr_in;

    // The previous beat's write lands on the same edge as this beat's read, so bypass it
    assign fwd_c  = wb_valid_q && (wb_addr_q == s1_addr_q);
    assign hit_c  = fwd_c || written_q[s1_addr_q] || !first_pass_q;
    assign base_c = fwd_c ? wb_data_q : rd_data_q;
    assign sum_c  = hit_c ? (base_c + s1_data_q) : s1_data_q;

    assign req_acc_c = rd_wr_q ? rd_data_q : '0;

    psum_requant #(
        .PSUM_BW  (PSUM_BW),
        .INPUT_BW (INPUT_BW)
    ) u_requant (
        .acc_i     (req_acc_c),
        .shift_i   (shift),
        .relu_en_i (relu_en),
        .q_c_o     (req_q_c)
    );

    // Simple dual-port buffer: one write from S1, one enable-gated synchronous read
    always_ff @(posedge clk) begin
        if (s1_valid_q) begin
            mem[s1_addr_q] <= sum_c;
        end
        if (rd_en_c) begin
            rd_data_q <= mem[rd_addr_c];
        end
    end

    always_comb begin
        state_d      = state_q;
        first_pass_d = first_pass_q;
        drained_d    = drained_q;
        last_seen_d  = last_seen_q;
        written_d    = written_q;
        s1_valid_d   = accept_c;
        s1_addr_d    = accept_c ? psum_addr_in : s1_addr_q;
        s1_data_d    = accept_c ? psum_data_in : s1_data_q;
        ptr_d        = ptr_q;
        rd_valid_d   = rd_valid_q;
        rd_wr_d      = rd_wr_q;
        rd_last_d    = rd_last_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        done_d       = 1'b0;

        if (s1_valid_q) begin
            written_d[s1_addr_q] = 1'b1;
        end

        // Drain datapath: read stage advances only when the output register can take it
        if (adv_c) begin
            out_valid_d = rd_valid_q;
            out_data_d  = rd_valid_q ? req_q_c : '0;
            out_last_d  = rd_valid_q && rd_last_q;
            rd_valid_d  = 1'b0;
        end
        if (issue_c) begin
            rd_valid_d = 1'b1;
            rd_wr_d    = written_q[ADDR_PSUM'(ptr_q)];
            rd_last_d  = (ptr_q == (n_beats_c - CNT_W'(1)));
            ptr_d      = ptr_q + CNT_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (acc_start) begin
                    state_d      = ACCUM;
                    first_pass_d = first_pass_q || drained_q;
                    drained_d    = 1'b0;
                    last_seen_d  = 1'b0;
                    if (first_pass_q || drained_q) begin
                        written_d = '0;
                    end
                end else if (drain_start) begin
                    state_d = DRAIN;
                    ptr_d   = '0;
                end
            end
            ACCUM: begin
                if (acc_last) begin
                    last_seen_d = 1'b1;
                end
                if (last_seen_q && !s1_valid_q) begin
                    state_d      = IDLE;
                    first_pass_d = 1'b0;
                    done_d       = 1'b1;
                end
            end
            DRAIN: begin
                if ((n_beats_c == '0) || (out_valid_q && out_ready && out_last_q)) begin
                    state_d   = IDLE;
                    drained_d = 1'b1;
                    done_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            first_pass_q <= 1'b1;
            drained_q    <= 1'b0;
            last_seen_q  <= 1'b0;
            written_q    <= '0;
            s1_valid_q   <= 1'b0;
            s1_addr_q    <= '0;
            s1_data_q    <= '0;
            wb_valid_q   <= 1'b0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
            ptr_q        <= '0;
            rd_valid_q   <= 1'b0;
            rd_wr_q      <= 1'b0;
            rd_last_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            first_pass_q <= first_pass_d;
            drained_q    <= drained_d;
            last_seen_q  <= last_seen_d;
            written_q    <= written_d;
            s1_valid_q   <= s1_valid_d;
            s1_addr_q    <= s1_addr_d;
            s1_data_q    <= s1_data_d;
            wb_valid_q   <= s1_valid_q;
            wb_addr_q    <= s1_addr_q;
            wb_data_q    <= sum_c;
            ptr_q        <= ptr_d;
            rd_valid_q   <= rd_valid_d;
            rd_wr_q      <= rd_wr_d;
            rd_last_q    <= rd_last_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
